// File: rtl/cp0_regfile_if.sv
// CP0 register file bus: W-stage control word, selects and operands in,
// read data, EPC/Status/Cause and interrupt request out.
interface cp0_regfile_if;
  logic [15:0] cp0_ctrl;
  logic        cp0_dsel;
  logic [2:0]  cp0_osel;
  logic [31:0] wdata;
  logic [31:0] pc_W;
  logic [31:0] mem_addr_W;
  logic [5:0]  hw_int;
  logic [31:0] rdata;
  logic [31:0] epc;
  logic [31:0] status;
  logic [31:0] cause;
  logic        int_req;

  modport master (
    output cp0_ctrl, cp0_dsel, cp0_osel, wdata, pc_W, mem_addr_W, hw_int,
    input  rdata, epc, status, cause, int_req
  );

  modport slave (
    input  cp0_ctrl, cp0_dsel, cp0_osel, wdata, pc_W, mem_addr_W, hw_int,
    output rdata, epc, status, cause, int_req
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt (TI/IP7).
module cp0_regfile #(
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input logic          clk,
  input logic          rst,
  cp0_regfile_if.slave bus
);

  localparam logic TICK_LAST = (COUNT_DIV == 2) ? 1'b1 : 1'b0;

  logic       compareWden, countWden, cp0Choice, badaddrWden, badaddrChoice;
  logic       statusWden, exlChoice, exlWden, bdWden, bdChoice, ip10Wden;
  logic       excCodeWden, epcWden;
  logic [2:0] excCodeChoice;

  assign {compareWden, countWden, cp0Choice, badaddrWden, badaddrChoice,
          statusWden, exlChoice, exlWden, bdWden, bdChoice, ip10Wden,
          excCodeWden, excCodeChoice, epcWden} = bus.cp0_ctrl;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  ipHi_q, ipHi_d;
  logic [1:0]  ipLo_q, ipLo_d;
  logic [4:0]  excCode_q, excCode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badVAddr_q, badVAddr_d;
  logic [31:0] count_q, count_d;
  logic        tick_q, tick_d;
  logic [31:0] compare_q, compare_d;

  // Status: an exception/ERET EXL update overrides the MTC0 EXL bit.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    if (statusWden) begin
      im_d  = bus.wdata[15:8];
      exl_d = bus.wdata[1];
      ie_d  = bus.wdata[0];
    end
    if (exlWden)
      exl_d = exlChoice;
  end

  always_comb begin
    bd_d      = bdWden ? bdChoice : bd_q;
    ipLo_d    = ip10Wden ? bus.wdata[9:8] : ipLo_q;
`ifdef CP0_TIMER_INT_EN
    ipHi_d    = {bus.hw_int[5] | ti_q, bus.hw_int[4:0]};
`else
    ipHi_d    = bus.hw_int;
`endif
    excCode_d = excCode_q;
    if (excCodeWden) begin
      case (excCodeChoice)
        3'b001:  excCode_d = 5'h04;
        3'b010:  excCode_d = 5'h05;
        3'b011:  excCode_d = 5'h08;
        3'b100:  excCode_d = 5'h09;
        3'b101:  excCode_d = 5'h0A;
        3'b110:  excCode_d = 5'h0C;
        3'b111:  excCode_d = 5'h00;
        default: excCode_d = excCode_q;
      endcase
    end
  end

  // EPC: an exception write wins over an MTC0 write on the same word.
  always_comb begin
    epc_d = epc_q;
    if (epcWden) begin
      if (cp0Choice)
        epc_d = bdChoice ? (bus.pc_W - 32'd4) : bus.pc_W;
      else if (bus.cp0_dsel)
        epc_d = bus.wdata;
    end
    badVAddr_d = badVAddr_q;
    if (badaddrWden)
      badVAddr_d = badaddrChoice ? bus.mem_addr_W : bus.pc_W;
  end

  // Count prescaler: a software write restarts the divide phase.
  always_comb begin
    count_d = count_q;
    tick_d  = (tick_q == TICK_LAST) ? 1'b0 : ~tick_q;
    if (countWden) begin
      count_d = bus.wdata;
      tick_d  = 1'b0;
    end else if (tick_q == TICK_LAST) begin
      count_d = count_q + 32'd1;
    end
    compare_d = compareWden ? bus.wdata : compare_q;
  end

  always_comb begin
    ti_d = 1'b0;
`ifdef CP0_TIMER_INT_EN
    if (compareWden)
      ti_d = 1'b0;
    else if (count_q == compare_q)
      ti_d = 1'b1;
    else
      ti_d = ti_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q       <= STATUS_RST[15:8];
      exl_q      <= STATUS_RST[1];
      ie_q       <= STATUS_RST[0];
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ipHi_q     <= '0;
      ipLo_q     <= '0;
      excCode_q  <= '0;
      epc_q      <= '0;
      badVAddr_q <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      compare_q  <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ipHi_q     <= ipHi_d;
      ipLo_q     <= ipLo_d;
      excCode_q  <= excCode_d;
      epc_q      <= epc_d;
      badVAddr_q <= badVAddr_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      compare_q  <= compare_d;
    end
  end

  logic [31:0] statusVal, causeVal;
  logic [7:0]  ipAll;

  assign ipAll     = {ipHi_q, ipLo_q};
  assign statusVal = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign causeVal  = {bd_q, ti_q, 14'b0, ipAll, 1'b0, excCode_q, 2'b0};

  always_comb begin
    case (bus.cp0_osel)
      3'b000:  bus.rdata = epc_q;
      3'b001:  bus.rdata = statusVal;
      3'b010:  bus.rdata = causeVal;
      3'b011:  bus.rdata = badVAddr_q;
      3'b100:  bus.rdata = count_q;
      3'b101:  bus.rdata = compare_q;
      default: bus.rdata = 32'h0;
    endcase
  end

  assign bus.epc     = epc_q;
  assign bus.status  = statusVal;
  assign bus.cause   = causeVal;
  assign bus.int_req = ie_q & ~exl_q & (|(ipAll & im_q));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (default COUNT_DIV=2).
module tb_cp0_regfile;

  localparam logic [15:0] C_COMPARE = 16'h8000;
  localparam logic [15:0] C_COUNT   = 16'h4000;
  localparam logic [15:0] C_CHOICE  = 16'h2000;
  localparam logic [15:0] C_BADW    = 16'h1000;
  localparam logic [15:0] C_BADC    = 16'h0800;
  localparam logic [15:0] C_STATUS  = 16'h0400;
  localparam logic [15:0] C_EXLC    = 16'h0200;
  localparam logic [15:0] C_EXLW    = 16'h0100;
  localparam logic [15:0] C_BDW     = 16'h0080;
  localparam logic [15:0] C_BDC     = 16'h0040;
  localparam logic [15:0] C_IP10    = 16'h0020;
  localparam logic [15:0] C_EXCW    = 16'h0010;
  localparam logic [15:0] C_EPC     = 16'h0001;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  int   failCount;
  logic [31:0] rd;
  logic        found;

  cp0_regfile_if bus();

  cp0_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus word for one clock, then back to an idle word.
  task automatic applyStimulus(input logic [15:0] ctrl, input logic dsel,
                               input logic [31:0] wd, input logic [31:0] pc,
                               input logic [31:0] addr);
    bus.cp0_ctrl   = ctrl;
    bus.cp0_dsel   = dsel;
    bus.wdata      = wd;
    bus.pc_W       = pc;
    bus.mem_addr_W = addr;
    @(posedge clk);
    #1;
    bus.cp0_ctrl = 16'h0;
    bus.cp0_dsel = 1'b0;
  endtask

  task automatic readSel(input logic [2:0] sel, output logic [31:0] value);
    bus.cp0_osel = sel;
    #1;
    value = bus.rdata;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rst            = 1'b1;
    bus.cp0_ctrl   = 16'h0;
    bus.cp0_dsel   = 1'b0;
    bus.cp0_osel   = 3'b000;
    bus.wdata      = 32'h0;
    bus.pc_W       = 32'h0;
    bus.mem_addr_W = 32'h0;
    bus.hw_int     = 6'b0;

    repeat (2) @(posedge clk);
    #1;
    readSel(3'b000, rd); checkOutput("rst_epc", rd, 32'h0);
    readSel(3'b001, rd); checkOutput("rst_status", rd, 32'h0040_0000);
    readSel(3'b010, rd); checkOutput("rst_cause", rd, 32'h0);
    readSel(3'b011, rd); checkOutput("rst_badvaddr", rd, 32'h0);
    readSel(3'b100, rd); checkOutput("rst_count", rd, 32'h0);
    readSel(3'b101, rd); checkOutput("rst_compare", rd, 32'h0);
    checkOutput("rst_intreq", {31'b0, bus.int_req}, 32'h0);
    rst = 1'b0;

    waitCycles(10);
    readSel(3'b100, rd); checkOutput("count_10clk", rd, 32'd5);
    readSel(3'b111, rd); checkOutput("osel7_zero", rd, 32'h0);

    applyStimulus(C_COMPARE, 1'b1, 32'h8000_0000, 32'h0, 32'h0);
    waitCycles(1);
    readSel(3'b101, rd); checkOutput("compare_wr", rd, 32'h8000_0000);

    bus.hw_int = 6'b000001;
    applyStimulus(C_STATUS, 1'b1, 32'h0000_FF01, 32'h0, 32'h0);
    checkOutput("mtc0_status", bus.status, 32'h0040_FF01);
    checkOutput("cause_ip2", bus.cause, 32'h0000_0400);
    checkOutput("intreq_hw", {31'b0, bus.int_req}, 32'h1);

    applyStimulus(C_CHOICE | C_EXLC | C_EXLW | C_BDW | C_EXCW | 16'h000E | C_EPC,
                  1'b0, 32'h0, 32'hBFC0_0100, 32'h0);
    checkOutput("exc_status", bus.status, 32'h0040_FF03);
    checkOutput("exc_epc", bus.epc, 32'hBFC0_0100);
    checkOutput("exc_cause", bus.cause, 32'h0000_0400);
    checkOutput("exc_intreq", {31'b0, bus.int_req}, 32'h0);

    bus.hw_int = 6'b0;
    waitCycles(1);
    applyStimulus(C_CHOICE | C_BADW | C_BADC | C_EXLC | C_EXLW | C_BDW | C_BDC |
                  C_EXCW | 16'h0002 | C_EPC, 1'b0, 32'h0, 32'h8000_1004, 32'h8000_2001);
    readSel(3'b011, rd); checkOutput("adel_badvaddr", rd, 32'h8000_2001);
    checkOutput("adel_epc", bus.epc, 32'h8000_0FF8 + 32'h8);
    readSel(3'b010, rd); checkOutput("adel_cause", rd, 32'h8000_0010);

    applyStimulus(C_EXLW, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("eret_status", bus.status, 32'h0040_FF01);
    checkOutput("eret_epc", bus.epc, 32'h8000_1000);

    applyStimulus(C_EPC, 1'b1, 32'h1234_5678, 32'hDEAD_BEEC, 32'h0);
    readSel(3'b000, rd); checkOutput("mtc0_epc", rd, 32'h1234_5678);

    applyStimulus(C_IP10, 1'b1, 32'h0000_0100, 32'h0, 32'h0);
    checkOutput("ip10_cause", bus.cause, 32'h8000_0110);
    checkOutput("ip10_intreq", {31'b0, bus.int_req}, 32'h1);

    applyStimulus(C_EXCW | 16'h000C, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("exc_0c", bus.cause, 32'h8000_0130);
    applyStimulus(C_EXCW, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("exc_keep", bus.cause, 32'h8000_0130);

    applyStimulus(C_BADW, 1'b0, 32'h0, 32'h0040_0020, 32'h9999_0000);
    readSel(3'b011, rd); checkOutput("badvaddr_pc", rd, 32'h0040_0020);

    applyStimulus(C_IP10 | C_STATUS, 1'b1, 32'h0000_8001, 32'h0, 32'h0);
    checkOutput("timer_status", bus.status, 32'h0040_8001);
    applyStimulus(C_COUNT, 1'b1, 32'h0, 32'h0, 32'h0);
    applyStimulus(C_COMPARE, 1'b1, 32'd4, 32'h0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cause[30]) begin
        found = 1'b1;
        break;
      end
      waitCycles(1);
    end
`ifdef CP0_TIMER_INT_EN
    checkOutput("ti_set", {31'b0, found}, 32'h1);
    waitCycles(1);
    checkOutput("ti_intreq", {31'b0, bus.int_req}, 32'h1);
    applyStimulus(C_COMPARE, 1'b1, 32'd100, 32'h0, 32'h0);
    checkOutput("ti_clear", {31'b0, bus.cause[30]}, 32'h0);
`else
    checkOutput("ti_held0", {31'b0, found}, 32'h0);
    checkOutput("ti_intreq0", {31'b0, bus.int_req}, 32'h0);
`endif

    applyStimulus(C_COUNT, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    readSel(3'b100, rd); checkOutput("count_max", rd, 32'hFFFF_FFFF);
    waitCycles(1);
    readSel(3'b100, rd); checkOutput("count_hold", rd, 32'hFFFF_FFFF);
    waitCycles(1);
    readSel(3'b100, rd); checkOutput("count_wrap", rd, 32'h0);

    waitCycles(6);
    readSel(3'b100, rd); checkOutput("count_run", rd, 32'd3);
    rst = 1'b1;
    #1;
    readSel(3'b100, rd); checkOutput("async_rst_count", rd, 32'h0);
    checkOutput("async_rst_status", bus.status, 32'h0040_0000);
    rst = 1'b0;
    waitCycles(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file that consumes the W-stage CP0 control bus and read/write selects.
- Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14).
- Drives the read mux, EPC for ERET redirect, and the pending-interrupt request back to the exception control logic.
- Implements the free-running Count timer, the Compare timer interrupt and hardware interrupt sampling.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1 or 2 supported).
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, all other bits 0).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cp0_ctrl  in  16  control bus, msb first: {Compare_wden, Count_wden, cp0_choice, badaddr_wden, badaddr_choice, Status_wden, EXL_choice, EXL_wden, BD_wden, BD_choice, IP10_wden, ExcCode_wden, ExcCode_choice[2:0], Epc_wden}.
- cp0_dsel  in  1  1 = write data comes from wdata (MTC0).
- cp0_osel  in  3  read select: 000 EPC, 001 Status, 010 Cause, 011 BadVAddr, 100 Count, 101 Compare; 110 and 111 read 0.
- wdata  in  32  MTC0 rt value.
- pc_W  in  32  PC of the W-stage instruction.
- mem_addr_W  in  32  load/store effective address.
- hw_int  in  6  external interrupt lines, level sensitive.
- rdata  out  32  combinational read of the selected register.
- epc  out  32  current EPC.
- status  out  32  current Status.
- cause  out  32  current Cause.
- int_req  out  1  interrupt pending and enabled.

Behaviour:
- Reset: BadVAddr=0, Count=0, Compare=0, Status=STATUS_RST, Cause=0, EPC=0, tick=0, int_req=0.
- All register updates take effect on the clk rising edge. Reads are combinational from current state; a same-cycle write is visible the next cycle.
- Status: writable bits are IM[15:8], EXL[1] and IE[0]. BEV[22] reads 1. All other bits read 0.
  - Status_wden writes those fields from wdata.
  - EXL_wden: EXL <= EXL_choice (1 = exception entry, 0 = ERET). This overrides the Status_wden EXL bit in the same cycle.
- Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]; all other bits read 0.
  - IP[7:2] are sampled every cycle from {hw_int[5]|TI, hw_int[4:0]}.
  - IP10_wden writes IP[9:8] from wdata[9:8].
  - BD_wden: BD <= BD_choice.
  - ExcCode_wden: ExcCode <= map(ExcCode_choice): 001 -> 0x04, 010 -> 0x05, 011 -> 0x08, 100 -> 0x09, 101 -> 0x0A, 110 -> 0x0C, 111 -> 0x00, 000 -> unchanged.
- EPC: when Epc_wden is asserted:
  - cp0_choice=1: EPC <= BD_choice ? pc_W-4 : pc_W.
  - else if cp0_dsel=1: EPC <= wdata.
  - Exception takes priority.
- BadVAddr: badaddr_wden loads badaddr_choice ? mem_addr_W : pc_W. Never written by MTC0.
- Count:
  - tick counter toggles or wraps every clock. Count += 1 when tick reaches COUNT_DIV-1. Count wraps 0xFFFF_FFFF -> 0.
  - Count_wden loads wdata and resets tick. A write beats a same-cycle increment.
- Compare: Compare_wden loads wdata and clears TI in the same edge.
- TI: set the cycle after Count == Compare with Compare_wden low. Remains set until a Compare write. Set has priority over nothing else.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). Registered-free; derived from current state.
- Simultaneous MTC0 plus exception on one bus word cannot occur (the decoder gates it). If it does, exception fields win and MTC0 fields still apply to non-overlapping registers.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Count restarts from 0 after deassertion.

Optional Feature:
- CP0_TIMER_INT_EN defined: Count/Compare comparison drives TI and IP7 as above.
- Undefined: TI is held 0; Cause.IP7 = hw_int[5] only. Count and Compare remain readable and writable; the compare logic is removed.

Test Plan:
- Reset then read all selects -> Status=0x0040_0000, all others 0, int_req=0. After 10 clocks with COUNT_DIV=2, Count=5.
- MTC0 Status=0x0000_FF01 (Status_wden, dsel=1), hw_int=6'b000001 -> Cause.IP2=1, int_req=1 next cycle. Then an exception bus word with ExcCode_choice=111 and BD_choice=0 at pc_W=0xBFC0_0100 -> EXL=1, ExcCode=0, EPC=0xBFC0_0100, int_req=0.
- Exception AdEL_LD (badaddr_wden=1, choice=1, ExcCode 001), BD_choice=1, pc_W=0x8000_1004, mem_addr_W=0x8000_2001 -> BadVAddr=0x8000_2001, EPC=0x8000_1000, Cause=0x8000_0010.
- ERET (EXL_wden=1, EXL_choice=0) -> EXL=0. epc is unchanged.
- With CP0_TIMER_INT_EN: Count=0 written, Compare=4 written, Status=0x0000_8001 -> TI=1 and int_req=1 about 9 cycles later. Compare rewritten to 100 -> TI=0 the next cycle. Without the macro, TI stays 0.
- Count written with 0xFFFF_FFFF -> reads 0 after COUNT_DIV more clocks. Asserting rst mid-count -> Count=0 immediately.
